// File: rtl/ndn_face_mux.sv
// ndn_face_mux: per-face ingress packet FIFOs forwarding whole packets round-robin
// to the PIT/FIB core, plus a one-byte multicast egress replicator.
module ndn_face_mux #(
  parameter int NUM_FACES  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FACE_W     = $clog2(NUM_FACES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_FACES-1:0]   in_valid_i,
  input  logic [8*NUM_FACES-1:0] in_data_i,
  input  logic [NUM_FACES-1:0]   in_last_i,
  output logic [NUM_FACES-1:0]   in_ready_o,
  output logic                   core_valid_o,
  output logic [7:0]             core_data_o,
  output logic                   core_last_o,
  output logic [FACE_W-1:0]      core_face_o,
  input  logic                   core_ready_i,
  input  logic                   eg_valid_i,
  input  logic [7:0]             eg_data_i,
  input  logic                   eg_last_i,
  input  logic [NUM_FACES-1:0]   eg_mask_i,
  output logic                   eg_ready_o,
  output logic [NUM_FACES-1:0]   out_valid_o,
  output logic [7:0]             out_data_o,
  output logic                   out_last_o,
  input  logic [NUM_FACES-1:0]   out_ready_i,
  output logic [8*NUM_FACES-1:0] drop_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [8:0]           mem_q       [NUM_FACES][FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q    [NUM_FACES];
  logic [AW:0]          wr_ptr_d    [NUM_FACES];
  logic [AW:0]          rd_ptr_q    [NUM_FACES];
  logic [AW:0]          rd_ptr_d    [NUM_FACES];
  logic [AW:0]          pkt_start_q [NUM_FACES];
  logic [AW:0]          pkt_start_d [NUM_FACES];
  logic [CW-1:0]        pkt_cnt_q   [NUM_FACES];
  logic [CW-1:0]        pkt_cnt_d   [NUM_FACES];
  logic [7:0]           drop_cnt_q  [NUM_FACES];
  logic [7:0]           drop_cnt_d  [NUM_FACES];
  logic [NUM_FACES-1:0] dropping_q, dropping_d;
  logic [NUM_FACES-1:0] full, in_acc, wr_en, has_pkt, commit, retire;

  state_e               state_q, state_d;
  logic [FACE_W-1:0]    grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
  logic [FACE_W:0]      cand;
  logic                 found;
  logic [8:0]           head;
  logic                 core_done;

  logic [7:0]           eg_data_q, eg_data_d;
  logic                 eg_last_q, eg_last_d;
  logic [NUM_FACES-1:0] pending_q, pending_d;

  // Fall-through read: the head byte of the granted FIFO is presented directly.
  assign head      = mem_q[grant_q][rd_ptr_q[grant_q][AW-1:0]];
  assign core_done = (state_q == ST_SEND) && core_ready_i && head[8];

  always_comb begin
    full       = '0;
    has_pkt    = '0;
    in_ready_o = '0;
    in_acc     = '0;
    wr_en      = '0;
    commit     = '0;
    retire     = '0;
    dropping_d = dropping_q;
    drop_cnt_o = '0;
    for (int i = 0; i < NUM_FACES; i++) begin
      wr_ptr_d[i]    = wr_ptr_q[i];
      rd_ptr_d[i]    = rd_ptr_q[i];
      pkt_start_d[i] = pkt_start_q[i];
      pkt_cnt_d[i]   = pkt_cnt_q[i];
      drop_cnt_d[i]  = drop_cnt_q[i];
      full[i]        = (wr_ptr_q[i] - rd_ptr_q[i]) == (AW+1)'(FIFO_DEPTH);
      has_pkt[i]     = pkt_cnt_q[i] != '0;
      in_ready_o[i]  = !full[i] || dropping_q[i] || !has_pkt[i];
      in_acc[i]      = in_valid_i[i] && in_ready_o[i];
      if (in_acc[i]) begin
        if (dropping_q[i]) begin
          if (in_last_i[i]) dropping_d[i] = 1'b0;
        end else if (!full[i]) begin
          wr_en[i]    = 1'b1;
          wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(1);
          if (in_last_i[i]) begin
            pkt_start_d[i] = wr_ptr_q[i] + (AW+1)'(1);
            commit[i]      = 1'b1;
          end
        end else begin
          // Packet larger than the FIFO: rewind and discard; a last byte here ends it.
          dropping_d[i] = !in_last_i[i];
          wr_ptr_d[i]   = pkt_start_q[i];
          if (drop_cnt_q[i] != 8'hFF) drop_cnt_d[i] = drop_cnt_q[i] + 8'd1;
        end
      end
      if ((state_q == ST_SEND) && core_ready_i && (grant_q == FACE_W'(i)))
        rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(1);
      retire[i] = core_done && (grant_q == FACE_W'(i));
      if (commit[i] && !retire[i])      pkt_cnt_d[i] = pkt_cnt_q[i] + CW'(1);
      else if (!commit[i] && retire[i]) pkt_cnt_d[i] = pkt_cnt_q[i] - CW'(1);
      drop_cnt_o[8*i +: 8] = drop_cnt_q[i];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_FACES; k++) begin
      cand = {1'b0, rr_ptr_q} + (FACE_W+1)'(k);
      if (cand >= (FACE_W+1)'(NUM_FACES)) cand = cand - (FACE_W+1)'(NUM_FACES);
      if (!found && has_pkt[cand[FACE_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[FACE_W-1:0];
      end
    end
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    core_last_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        core_valid_o = 1'b1;
        core_data_o  = head[7:0];
        core_last_o  = head[8];
        if (core_done) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_face_o = grant_q;

  assign eg_ready_o  = (pending_q & ~out_ready_i) == '0;
  assign out_valid_o = pending_q;
  assign out_data_o  = eg_data_q;
  assign out_last_o  = eg_last_q;

  always_comb begin
    pending_d = pending_q & ~out_ready_i;
    eg_data_d = eg_data_q;
    eg_last_d = eg_last_q;
    if (eg_valid_i && eg_ready_o) begin
      pending_d = eg_mask_i;
      eg_data_d = eg_data_i;
      eg_last_d = eg_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_FACES; i++)
      if (wr_en[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= {in_last_i[i], in_data_i[8*i +: 8]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_FACES; i++) begin
        wr_ptr_q[i]    <= '0;
        rd_ptr_q[i]    <= '0;
        pkt_start_q[i] <= '0;
        pkt_cnt_q[i]   <= '0;
        drop_cnt_q[i]  <= '0;
      end
      dropping_q <= '0;
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= FACE_W'(NUM_FACES - 1);
      pending_q  <= '0;
      eg_data_q  <= '0;
      eg_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FACES; i++) begin
        wr_ptr_q[i]    <= wr_ptr_d[i];
        rd_ptr_q[i]    <= rd_ptr_d[i];
        pkt_start_q[i] <= pkt_start_d[i];
        pkt_cnt_q[i]   <= pkt_cnt_d[i];
        drop_cnt_q[i]  <= drop_cnt_d[i];
      end
      dropping_q <= dropping_d;
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      eg_data_q  <= eg_data_d;
      eg_last_q  <= eg_last_d;
    end
  end
endmodule

// File: tb/tb_ndn_face_mux.sv
// Scoreboard bench for ndn_face_mux: directed packets with expected core/egress
// bytes queued at issue time and popped by independent monitors.
module tb_ndn_face_mux;
  localparam int NF = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] in_valid, in_last, in_ready;
  logic [8*NF-1:0] in_data;
  logic          core_valid, core_last, core_ready;
  logic [7:0]    core_data;
  logic [FW-1:0] core_face;
  logic          eg_valid, eg_last, eg_ready;
  logic [7:0]    eg_data;
  logic [NF-1:0] eg_mask, out_valid, out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic [8*NF-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [10:0] core_exp[$];
  logic [10:0] eg_exp[$];

  always #5 clk = ~clk;

  ndn_face_mux #(.NUM_FACES(NF), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(in_ready),
    .core_valid_o(core_valid), .core_data_o(core_data), .core_last_o(core_last),
    .core_face_o(core_face), .core_ready_i(core_ready),
    .eg_valid_i(eg_valid), .eg_data_i(eg_data), .eg_last_i(eg_last), .eg_mask_i(eg_mask),
    .eg_ready_o(eg_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_last_o(out_last), .out_ready_i(out_ready), .drop_cnt_o(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && core_valid && core_ready) begin
      if (core_exp.size() == 0) chk("core_unexpected", {core_face, core_last, core_data}, 32'hFFFF_FFFF);
      else chk("core_byte", {core_face, core_last, core_data}, core_exp.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int f = 0; f < NF; f++) begin
        if (out_valid[f] && out_ready[f]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < eg_exp.size(); j++)
            if (idx < 0 && eg_exp[j][10:9] == FW'(f)) idx = j;
          if (idx < 0) chk("egress_unexpected", {FW'(f), out_last, out_data}, 32'hFFFF_FFFF);
          else begin
            chk("egress_byte", {FW'(f), out_last, out_data}, eg_exp[idx]);
            eg_exp.delete(idx);
          end
        end
      end
    end
  end

  task automatic send_pkt(input int f, input int n, input logic [7:0] base, input bit fwd,
                          output int stalls);
    logic [7:0] d;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      int g;
      d = base + 8'(k);
      in_valid[f] = 1'b1;
      in_data[8*f +: 8] = d;
      in_last[f] = (k == n - 1);
      if (fwd) core_exp.push_back({FW'(f), (k == n - 1), d});
      g = 0;
      @(negedge clk);
      while (!in_ready[f] && g < 200) begin
        g++;
        @(negedge clk);
      end
      stalls += g;
      if (g >= 200) chk("in_ready_timeout", {31'd0, in_ready[f]}, 1);
      @(posedge clk); #1;
    end
    in_valid[f] = 1'b0;
    in_last[f]  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((core_exp.size() != 0 || eg_exp.size() != 0) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) chk("drain_timeout", core_exp.size() + eg_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_core_last", core_last, 0);
    chk("rst_core_face", core_face, 0);
    chk("rst_eg_ready", eg_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; core_ready = 1'b1;
    eg_valid = 1'b0; eg_data = '0; eg_last = 1'b0; eg_mask = '0; out_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single 3-byte packet on face 2, first byte two cycles after last accept
    send_pkt(2, 3, 8'hA1, 1, st);
    @(negedge clk); chk("lat_cycle1_valid", core_valid, 0);
    @(negedge clk); chk("lat_cycle2_valid", core_valid, 1);
    chk("lat_face", core_face, 2);
    wait_drain();

    // Packets waiting on faces 0,1,3 plus a second face-0 packet: order 0,1,3,0
    core_ready = 1'b0;
    send_pkt(0, 2, 8'h10, 1, st);
    send_pkt(1, 3, 8'h20, 1, st);
    send_pkt(3, 2, 8'h30, 1, st);
    send_pkt(0, 2, 8'h40, 1, st);
    core_ready = 1'b1;
    wait_drain();

    // Oversized 17-byte packet on face 1 is dropped, following packet intact
    send_pkt(1, 17, 8'h60, 0, st);
    chk("drop_in_ready_high", st, 0);
    chk("drop_cnt_after", drop_cnt, 32'h0000_0100);
    send_pkt(1, 4, 8'h70, 1, st);
    wait_drain();
    chk("drop_cnt_stable", drop_cnt, 32'h0000_0100);

    // core_ready toggling every cycle during an 8-byte packet
    core_ready = 1'b0;
    send_pkt(3, 8, 8'h80, 1, st);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      core_ready = ~core_ready;
    end
    core_ready = 1'b1;
    wait_drain();

    // Egress 0x55 to faces 0 and 2, face 2 stalls three cycles
    out_ready = 4'b0001;
    eg_valid = 1'b1; eg_data = 8'h55; eg_last = 1'b1; eg_mask = 4'b0101;
    eg_exp.push_back({2'd0, 1'b1, 8'h55});
    eg_exp.push_back({2'd2, 1'b1, 8'h55});
    @(negedge clk); chk("eg_ready_c0", eg_ready, 1);
    @(posedge clk); #1; eg_valid = 1'b0;
    @(negedge clk); chk("eg_ready_c1", eg_ready, 0); chk("out_valid_c1", out_valid, 4'b0101);
    @(negedge clk); chk("eg_ready_c2", eg_ready, 0); chk("out_valid_c2", out_valid, 4'b0100);
    @(negedge clk); chk("eg_ready_c3", eg_ready, 0);
    @(posedge clk); #1; out_ready = 4'b0101;
    @(negedge clk); chk("out_valid_c4", out_valid, 4'b0100); chk("eg_ready_c4", eg_ready, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("out_valid_c5", out_valid, 0);

    // Mask 0 byte is accepted and never presented
    @(posedge clk); #1;
    eg_valid = 1'b1; eg_data = 8'h66; eg_last = 1'b0; eg_mask = 4'b0000;
    @(negedge clk); chk("eg_ready_mask0", eg_ready, 1);
    @(posedge clk); #1; eg_valid = 1'b0;
    @(negedge clk); chk("out_valid_mask0", out_valid, 0);

    // Back-to-back egress at full throughput
    @(posedge clk); #1;
    out_ready = 4'b1111;
    for (int b = 0; b < 3; b++) begin
      logic [NF-1:0] m;
      m = (b == 0) ? 4'b1111 : (b == 1) ? 4'b0010 : 4'b1000;
      eg_valid = 1'b1; eg_data = 8'h91 + 8'(b); eg_last = (b == 2); eg_mask = m;
      for (int f = 0; f < NF; f++)
        if (m[f]) eg_exp.push_back({FW'(f), (b == 2), 8'h91 + 8'(b)});
      @(negedge clk); chk("eg_ready_burst", eg_ready, 1);
      @(posedge clk); #1;
    end
    eg_valid = 1'b0;
    wait_drain();

    // Reset mid-SEND, with pending egress and a partial ingress packet
    core_ready = 1'b0;
    send_pkt(0, 3, 8'hB0, 0, st);
    repeat (2) @(posedge clk);
    @(negedge clk); chk("pre_rst_send", core_valid, 1);
    @(posedge clk); #1;
    out_ready = '0; eg_valid = 1'b1; eg_data = 8'hE7; eg_last = 1'b1; eg_mask = 4'b0110;
    @(posedge clk); #1;
    eg_valid = 1'b0; in_valid[2] = 1'b1; in_data[23:16] = 8'hD0; in_last[2] = 1'b0;
    @(posedge clk); #1; in_data[23:16] = 8'hD1;
    @(posedge clk); #1;
    @(negedge clk); chk("pre_rst_pending", out_valid, 4'b0110);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = '1; core_ready = 1'b1;
    send_pkt(0, 4, 8'hC0, 1, st);
    @(negedge clk); chk("post_rst_lat1", core_valid, 0);
    @(negedge clk); chk("post_rst_lat2", core_valid, 1);
    chk("post_rst_face", core_face, 0);
    wait_drain();

    chk("core_queue_empty", core_exp.size(), 0);
    chk("egress_queue_empty", eg_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ndn_face_mux.md
# ndn_face_mux

Parametrised N-face packet multiplexer for the NDN router: the next-generation front end replacing the single SPI-interface path. Buffers byte-stream packets arriving on NUM_FACES faces in per-face FIFOs and forwards only complete packets, round-robin, into the single PIT/FIB core stream, tagged with the source face. Replicates core egress bytes to any subset of faces (multicast for Data satisfying several PIT entries). Oversized ingress packets are dropped and counted.

## Interface
- NUM_FACES, 4, number of faces (>=2)
- FIFO_DEPTH, 16, bytes per face ingress FIFO (power of 2, >=2)
- FACE_W, $clog2(NUM_FACES), face index width (derived)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  NUM_FACES  per-face ingress byte valid
- in_data  in  8*NUM_FACES  face i byte on [8i+7:8i]
- in_last  in  NUM_FACES  final byte of packet
- in_ready  out  NUM_FACES  per-face ingress ready
- core_valid  out  1  byte to core valid
- core_data  out  8  byte to core
- core_last  out  1  final byte of packet to core
- core_face  out  FACE_W  source face of current packet
- core_ready  in  1  core accepts byte
- eg_valid  in  1  egress byte valid from core
- eg_data  in  8  egress byte
- eg_last  in  1  final egress byte
- eg_mask  in  NUM_FACES  destination face bitmap
- eg_ready  out  1  egress accepted
- out_valid  out  NUM_FACES  per-face egress valid
- out_data  out  8  shared egress byte
- out_last  out  1  shared egress last
- out_ready  in  NUM_FACES  per-face egress ready
- drop_cnt  out  8*NUM_FACES  per-face saturating dropped-packet count

## Operation
- Ingress per face: circular FIFO storing {last,data}; wr_ptr, rd_ptr, pkt_start, pkt_cnt (committed packets in FIFO). Transfer = in_valid&in_ready.
- in_ready[i] = !full | dropping | (pkt_cnt==0).
- Accepted byte, not dropping, FIFO not full: written; if in_last, pkt_start<=wr_ptr+1, pkt_cnt+1.
- Accepted byte when full and pkt_cnt==0 (packet exceeds FIFO_DEPTH): enter dropping, wr_ptr<=pkt_start, drop_cnt+1 (saturate 255). While dropping, bytes discarded; the in_last byte clears dropping.
- Full with pkt_cnt>0: in_ready low until head packet drains.
- Arbiter FSM: IDLE, SEND. IDLE: scan faces starting at rr_ptr+1 mod NUM_FACES, first with pkt_cnt>0 is granted, core_face<=grant, go SEND. SEND: core_valid=1, core_data/core_last = head of granted FIFO (fall-through). On transfer rd_ptr+1; on last-byte transfer pkt_cnt-1, rr_ptr<=grant, go IDLE.
- Simultaneous commit and completion on same face: pkt_cnt unchanged.
- Egress: one-byte holding register plus pending[NUM_FACES]. out_valid=pending; out_data/out_last from register. pending[i] clears on out_valid[i]&out_ready[i].
- eg_ready = ((pending & ~out_ready)==0). On eg transfer: register<=eg_data/eg_last, pending<=eg_mask. eg_mask==0: byte accepted and discarded.

## Timing
- Reset: all FIFOs empty, pkt_cnt=0, dropping=0, drop_cnt=0, FSM IDLE, rr_ptr=NUM_FACES-1 (face 0 first), pending=0; outputs: in_ready all 1, core_valid 0, core_data 0, core_last 0, core_face 0, eg_ready 1, out_valid 0, out_data 0, out_last 0. Reset mid-packet discards everything.
- Latency: last ingress byte accepted cycle t -> core_valid with first byte at t+2 (when FSM idle).
- Core stream: one byte per cycle while core_ready high; one idle cycle between packets (IDLE).
- Egress: full throughput, one byte/cycle when all masked faces ready; byte held until every masked face has taken it; faces may accept in different cycles.
- core_valid/out_valid never depend combinationally on ready; eg_ready depends combinationally on out_ready only.

## Test plan
- Single packet 3 bytes 0xA1,0xA2,0xA3(last) on face 2 -> core_face=2, same bytes with core_last on 0xA3, first core_valid 2 cycles after last accept.
- Complete packets waiting on faces 0,1,3 simultaneously -> served order 0,1,3, then new packet on face 0 served after 3.
- 17-byte packet into FIFO_DEPTH=16 face 1 -> never reaches core, drop_cnt[1]=1, in_ready stays high, next 4-byte packet forwarded intact.
- core_ready toggled every cycle during 8-byte packet -> all 8 bytes delivered in order, no duplication.
- Egress byte 0x55 mask 4'b0101, out_ready[0]=1, out_ready[2] low 3 cycles -> face 0 takes it cycle 1, face 2 on cycle 4, eg_ready low cycles 1-3; mask 0 byte accepted with no out_valid.
- rst asserted mid-ingress and mid-SEND -> all outputs to reset values next cycle; subsequent packet on face 0 forwarded normally.
